// File: rtl/index_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module      : index_frame_decoder
// Description : Receives encoded indices under valid/ready. Each accepted
//               index produces a registered one-hot pulse and is OR-folded
//               into a frame mask. A beat marked last closes the frame, and
//               the rebuilt request vector, beat count and duplicate flag are
//               then held under an output valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module index_frame_decoder #(
  parameter int WIDTH = 8,
  parameter int IW    = 3,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IW-1:0]    in_idx,
  input  logic             in_last,
  output logic [WIDTH-1:0] onehot,
  output logic             onehot_valid,
  output logic [WIDTH-1:0] vec,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic [CW-1:0]    count,
  output logic             dup_err
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_mask;
  logic [CW-1:0]      r_cnt;
  logic               r_dup;
  logic [WIDTH-1:0]   r_onehot;
  logic               r_onehot_valid;
  logic [WIDTH-1:0]   r_vec;
  logic               r_vec_valid;
  logic [CW-1:0]      r_count;
  logic               r_dup_err;

  logic               w_accept;
  logic [WIDTH-1:0]   w_dec;
  logic               w_hit;
  logic [CW-1:0]      w_cnt_next;

  // Ready is gated by reset so no beat can be taken while the block is held.
  assign in_ready   = (r_state == ACCUM) && !rst;
  assign w_accept   = in_valid && in_ready;
  assign w_dec      = {{(WIDTH-1){1'b0}}, 1'b1} << in_idx;
  assign w_hit      = |(r_mask & w_dec);
  // Beat counter sticks at all-ones rather than wrapping on long frames.
  assign w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  // Frame FSM: accumulate beats, then hold the frame result until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ACCUM;
      r_mask         <= '0;
      r_cnt          <= '0;
      r_dup          <= 1'b0;
      r_onehot       <= '0;
      r_onehot_valid <= 1'b0;
      r_vec          <= '0;
      r_vec_valid    <= 1'b0;
      r_count        <= '0;
      r_dup_err      <= 1'b0;
    end else begin
      r_onehot_valid <= 1'b0;
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            r_onehot       <= w_dec;
            r_onehot_valid <= 1'b1;
            if (in_last) begin
              // Publish the frame including this beat, then start clean.
              r_vec       <= r_mask | w_dec;
              r_count     <= w_cnt_next;
              r_dup_err   <= r_dup | w_hit;
              r_vec_valid <= 1'b1;
              r_state     <= HOLD;
              r_mask      <= '0;
              r_cnt       <= '0;
              r_dup       <= 1'b0;
            end else begin
              r_mask <= r_mask | w_dec;
              r_cnt  <= w_cnt_next;
              r_dup  <= r_dup | w_hit;
            end
          end
        end
        HOLD: begin
          // Result fields stay untouched; only the valid flag drops.
          if (vec_ready) begin
            r_vec_valid <= 1'b0;
            r_state     <= ACCUM;
          end
        end
        default: begin
          r_state <= ACCUM;
        end
      endcase
    end
  end

  assign onehot       = r_onehot;
  assign onehot_valid = r_onehot_valid;
  assign vec          = r_vec;
  assign vec_valid    = r_vec_valid;
  assign count        = r_count;
  assign dup_err      = r_dup_err;

endmodule
`default_nettype wire

// File: tb/tb_index_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_index_frame_decoder
// Description : Directed, table-driven bench for index_frame_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_index_frame_decoder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_idx;
  logic       in_last;
  logic [7:0] onehot;
  logic       onehot_valid;
  logic [7:0] vec;
  logic       vec_valid;
  logic       vec_ready;
  logic [3:0] count;
  logic       dup_err;

  int n_total;
  int n_pass;

  index_frame_decoder #(
    .WIDTH(8),
    .IW   (3),
    .CW   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_idx      (in_idx),
    .in_last     (in_last),
    .onehot      (onehot),
    .onehot_valid(onehot_valid),
    .vec         (vec),
    .vec_valid   (vec_valid),
    .vec_ready   (vec_ready),
    .count       (count),
    .dup_err     (dup_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One vector: inputs for a cycle, in_ready expected before the edge,
  // registered outputs expected after it. fchk gates vec/count/dup_err.
  typedef struct packed {
    logic       r;
    logic       v;
    logic [2:0] i;
    logic       l;
    logic       vr;
    logic       rdy;
    logic [7:0] oh;
    logic       ohv;
    logic [7:0] vec;
    logic       vv;
    logic [3:0] cnt;
    logic       dup;
    logic       fchk;
  } row_t;

  row_t rows[$];

  function automatic row_t mk(input logic r, v, input logic [2:0] i,
                              input logic l, vr, rdy, input logic [7:0] oh,
                              input logic ohv, input logic [7:0] ve,
                              input logic vv, input logic [3:0] cnt,
                              input logic dup, fchk);
    row_t x;
    x = '{r:r, v:v, i:i, l:l, vr:vr, rdy:rdy, oh:oh, ohv:ohv,
          vec:ve, vv:vv, cnt:cnt, dup:dup, fchk:fchk};
    return x;
  endfunction

  task automatic check(input string name, input int tag,
                       input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s (step %0d): got %0h expected %0h", name, tag, act, exp);
    else
      n_pass++;
  endtask

  task automatic drive(input logic r, v, input logic [2:0] i,
                       input logic l, vr);
    rst       = r;
    in_valid  = v;
    in_idx    = i;
    in_last   = l;
    vec_ready = vr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

    //            r  v  i  l vr rdy  oh  ohv vec  vv cnt dup fchk
    // Reset held two cycles with a valid beat pending.
    rows.push_back(mk(1, 1, 5, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1));
    rows.push_back(mk(1, 1, 5, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1));
    // Basic frame 6, 7, 4(last).
    rows.push_back(mk(0, 1, 6, 0, 1, 1, 8'h40, 1, 8'h00, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 7, 0, 1, 1, 8'h80, 1, 8'h00, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 4, 1, 1, 1, 8'h10, 1, 8'hD0, 1, 3, 0, 1));
    rows.push_back(mk(0, 0, 0, 0, 1, 0, 8'h10, 0, 8'h00, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 1, 1, 8'h10, 0, 8'h00, 0, 0, 0, 0));
    // Duplicates 6, 6, 7, 4, 5, 5(last), closed into backpressure.
    rows.push_back(mk(0, 1, 6, 0, 0, 1, 8'h40, 1, 8'h00, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 6, 0, 0, 1, 8'h40, 1, 8'h00, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 7, 0, 0, 1, 8'h80, 1, 8'h00, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 4, 0, 0, 1, 8'h10, 1, 8'h00, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 5, 0, 0, 1, 8'h20, 1, 8'h00, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 5, 1, 0, 1, 8'h20, 1, 8'hF0, 1, 6, 1, 1));
    // Five stalled cycles with a beat offered: nothing may move.
    for (int k = 0; k < 5; k++)
      rows.push_back(mk(0, 1, 3, 0, 0, 0, 8'h20, 0, 8'hF0, 1, 6, 1, 1));
    rows.push_back(mk(0, 0, 0, 0, 1, 0, 8'h20, 0, 8'h00, 0, 0, 0, 0));
    // Frame of beat 2(last).
    rows.push_back(mk(0, 1, 2, 1, 1, 1, 8'h04, 1, 8'h04, 1, 1, 0, 1));
    // Single-beat frame 0(last), first offered while still holding.
    rows.push_back(mk(0, 1, 0, 1, 1, 0, 8'h04, 0, 8'h00, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 0, 1, 1, 1, 8'h01, 1, 8'h01, 1, 1, 0, 1));
    rows.push_back(mk(0, 0, 0, 0, 1, 0, 8'h01, 0, 8'h00, 0, 0, 0, 0));
    // Reset mid-frame: 1, 2, reset, 3(last).
    rows.push_back(mk(0, 1, 1, 0, 1, 1, 8'h02, 1, 8'h00, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 2, 0, 1, 1, 8'h04, 1, 8'h00, 0, 0, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1));
    rows.push_back(mk(0, 1, 3, 1, 1, 1, 8'h08, 1, 8'h08, 1, 1, 0, 1));
    rows.push_back(mk(0, 0, 0, 0, 1, 0, 8'h08, 0, 8'h00, 0, 0, 0, 0));
    // Input stall: valid 1,0,0,1(last); idle cycles carry junk idx/last.
    rows.push_back(mk(0, 1, 2, 0, 1, 1, 8'h04, 1, 8'h00, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 7, 1, 1, 1, 8'h04, 0, 8'h00, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 7, 1, 1, 1, 8'h04, 0, 8'h00, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 5, 1, 1, 1, 8'h20, 1, 8'h24, 1, 2, 0, 1));
    rows.push_back(mk(0, 0, 0, 0, 1, 0, 8'h20, 0, 8'h00, 0, 0, 0, 0));

    for (int n = 0; n < rows.size(); n++) begin
      drive(rows[n].r, rows[n].v, rows[n].i, rows[n].l, rows[n].vr);
      #1;
      check("in_ready", n, {31'd0, in_ready}, {31'd0, rows[n].rdy});
      tick();
      check("onehot", n, {24'd0, onehot}, {24'd0, rows[n].oh});
      check("onehot_valid", n, {31'd0, onehot_valid}, {31'd0, rows[n].ohv});
      check("vec_valid", n, {31'd0, vec_valid}, {31'd0, rows[n].vv});
      if (rows[n].fchk) begin
        check("vec", n, {24'd0, vec}, {24'd0, rows[n].vec});
        check("count", n, {28'd0, count}, {28'd0, rows[n].cnt});
        check("dup_err", n, {31'd0, dup_err}, {31'd0, rows[n].dup});
      end
    end

    // Long frame: 17 beats cycling all indices; count must stop at 15.
    for (int b = 0; b < 17; b++) begin
      drive(1'b0, 1'b1, 3'(b % 8), (b == 16), 1'b0);
      tick();
      check("sat_vec_valid", 100 + b, {31'd0, vec_valid}, {31'd0, (b == 16)});
    end
    drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    check("sat_vec", 200, {24'd0, vec}, 32'h0000_00FF);
    check("sat_count", 200, {28'd0, count}, 32'd15);
    check("sat_dup_err", 200, {31'd0, dup_err}, 32'd1);
    drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    tick();
    check("sat_release", 201, {31'd0, vec_valid}, 32'd0);
    tick();
    check("sat_in_ready", 202, {31'd0, in_ready}, 32'd1);

    // Counter must restart from zero after a saturated frame.
    drive(1'b0, 1'b1, 3'd6, 1'b1, 1'b1);
    tick();
    check("post_sat_count", 203, {28'd0, count}, 32'd1);
    check("post_sat_vec", 203, {24'd0, vec}, 32'h0000_0040);
    check("post_sat_dup", 203, {31'd0, dup_err}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
